sc_image_serial_receiver: RTL and testbench
===========================================

Name: sc_image_serial_receiver

Overview:
- Front-end deserializer for the image-load path. It accepts a serial bit stream under a valid/ready handshake and assembles it into row bytes.
- It produces the command, bit-index and row-index signals consumed by the image-loader state machine (which drives active-low row-load strobes when bit index reaches 7 under command 2'b00).
- It enforces a hold-off after each completed byte so the row index is stable while the downstream loader samples it.

Parameters:
- ROWS, 8, number of row bytes per frame (1..16, fits 4-bit row index)
- BITS_PER_ROW, 8, bits per row byte (fixed at 8 for the current loader)
- GAP_CYCLES, 2, ready-low hold-off after each completed byte (minimum 2)

Ports:
- i_CLOCK  in  1  single system clock, rising edge
- i_RESET  in  1  synchronous, active-high reset
- i_START  in  1  begin frame; sampled only in IDLE
- i_CMD  in  2  command, latched on accepted start
- i_SDATA  in  1  serial data bit, MSB first
- i_SVALID  in  1  serial bit valid
- o_SREADY  out  1  receiver can accept a bit this cycle
- o_CMD  out  2  latched frame command
- o_DATA_COUNT  out  7  index of most recently accepted bit in current byte (0..7)
- o_ROW  out  4  index of row byte currently being assembled
- o_BYTE  out  8  shift register contents
- o_BYTE_VALID  out  1  one-cycle pulse: byte complete
- o_FRAME_DONE  out  1  one-cycle pulse: all ROWS bytes received
- o_BUSY  out  1  high in any state other than IDLE

Behaviour:
- Reset: synchronous. When i_RESET is high at a clock edge, the block enters IDLE and every output is 0 (o_SREADY=0, o_CMD=2'b00, o_DATA_COUNT=0, o_ROW=0, o_BYTE=0, o_BYTE_VALID=0, o_FRAME_DONE=0, o_BUSY=0). This also holds mid-frame; the partial byte is discarded.
- Accept is defined as i_SVALID & o_SREADY at the clock edge. A bit presented while o_SREADY=0 is ignored, never queued.
- States:
  - IDLE: o_SREADY=0. On i_START: latch i_CMD into o_CMD; clear o_ROW, o_DATA_COUNT, o_BYTE and the internal bit counter; go to RECEIVE.
  - RECEIVE: o_SREADY=1. On accept:
    - o_BYTE <= {o_BYTE[6:0], i_SDATA}.
    - If the previous byte is complete (8 bits held), this bit starts a new byte: o_ROW increments, o_DATA_COUNT <= 0, bit counter <= 1.
    - Otherwise o_DATA_COUNT <= bit counter (the old value), and the bit counter increments.
    - The very first bit of a frame gives o_DATA_COUNT=0 with o_ROW unchanged.
    - When the 8th bit is accepted: o_DATA_COUNT=7, o_BYTE_VALID=1 in the following cycle, go to GAP.
  - GAP: o_SREADY=0 for exactly GAP_CYCLES cycles; o_ROW, o_DATA_COUNT and o_BYTE hold.
    - Exit to DONE if o_ROW == ROWS-1, else to RECEIVE.
  - DONE: one cycle, o_FRAME_DONE=1, then IDLE.
- Output holds:
  - o_DATA_COUNT holds 7 after a completed byte until the first bit of the next byte is accepted. The downstream loader relies on this to leave its wait state.
  - o_ROW changes only on acceptance of the first bit of a new byte, never within the GAP_CYCLES window.
- In IDLE after a frame, o_ROW, o_DATA_COUNT and o_BYTE keep their last values until the next i_START.
- Simultaneous events:
  - i_START outside IDLE is ignored.
  - i_START and i_SVALID together in IDLE: the bit is not accepted (o_SREADY=0 that cycle).
  - i_RESET has priority over everything.
- Latency: 1 cycle from the accepting edge to updated outputs. Throughput: BITS_PER_ROW + GAP_CYCLES cycles per byte at full valid rate.

Decomposition:
- Shared package holds:
  - state encodings (IDLE=0, RECEIVE=1, GAP=2, DONE=3)
  - command codes (CMD_LOAD_IMAGE=2'b00)
  - widths (DATA_COUNT_W=7, ROW_W=4)
- No sub-module is needed. The GAP down-counter and the bit counter stay inline in one module with separate next-state, state-register and output processes.

Test Plan:
- Reset, then i_START with i_CMD=00, then 8 bits 1,0,1,1,0,0,1,0 at full valid rate -> o_BYTE=8'hB2 and o_DATA_COUNT=7; o_BYTE_VALID pulses one cycle; o_SREADY=0 for exactly 2 cycles; o_ROW=0 throughout.
- Full frame, 8 bytes 8'h01..8'h08 -> o_ROW steps 0..7, each step on the first bit of the next byte; o_FRAME_DONE pulses once after the last GAP; returns to IDLE with o_BUSY=0.
- i_SVALID toggled randomly plus bits driven during GAP -> only handshaked bits are captured; bits presented during GAP are dropped; byte contents match the reference model.
- i_RESET asserted after 3 bits of row 2 -> next cycle all outputs are 0 and state is IDLE; a fresh i_START restarts at row 0.
- i_START pulsed during RECEIVE with i_CMD=01 -> o_CMD stays 00 and the frame continues unaffected.
- Integrated with the loader (i_CMD=00): exactly one active-low row strobe per byte, matching o_ROW; no strobe is issued for i_CMD=01.

Source files
------------

// File: rtl/sc_image_serial_receiver_pkg.sv
// Shared encodings and widths for the image-load serial receiver.
package sc_image_serial_receiver_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RECEIVE = 2'd1,
    ST_GAP     = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  localparam logic [1:0] CMD_LOAD_IMAGE = 2'b00;

  localparam int DATA_COUNT_W = 7;
  localparam int ROW_W        = 4;

endpackage

// File: rtl/sc_image_serial_receiver.sv
// Serial-to-row-byte deserializer feeding the image loader; holds the row
// index stable for a fixed hold-off after every completed byte.
module sc_image_serial_receiver
  import sc_image_serial_receiver_pkg::*;
#(
  parameter int ROWS         = 8,
  parameter int BITS_PER_ROW = 8,
  parameter int GAP_CYCLES   = 2
) (
  input  logic                    i_CLOCK,
  input  logic                    i_RESET,
  input  logic                    i_START,
  input  logic [1:0]              i_CMD,
  input  logic                    i_SDATA,
  input  logic                    i_SVALID,
  output logic                    o_SREADY,
  output logic [1:0]              o_CMD,
  output logic [DATA_COUNT_W-1:0] o_DATA_COUNT,
  output logic [ROW_W-1:0]        o_ROW,
  output logic [7:0]              o_BYTE,
  output logic                    o_BYTE_VALID,
  output logic                    o_FRAME_DONE,
  output logic                    o_BUSY
);

  localparam int BIT_CNT_W = $clog2(BITS_PER_ROW + 1);
  localparam int GAP_W     = $clog2(GAP_CYCLES);

  localparam logic [BIT_CNT_W-1:0] BITS_FULL = BIT_CNT_W'(BITS_PER_ROW);
  localparam logic [BIT_CNT_W-1:0] BITS_LAST = BIT_CNT_W'(BITS_PER_ROW - 1);
  localparam logic [ROW_W-1:0]     LAST_ROW  = ROW_W'(ROWS - 1);
  localparam logic [GAP_W-1:0]     GAP_LOAD  = GAP_W'(GAP_CYCLES - 1);

  state_e                  state_q, state_d;
  logic [1:0]              cmd_q, cmd_d;
  logic [DATA_COUNT_W-1:0] data_count_q, data_count_d;
  logic [ROW_W-1:0]        row_q, row_d;
  logic [7:0]              byte_q, byte_d;
  logic [BIT_CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [GAP_W-1:0]        gap_q, gap_d;
  logic                    byte_valid_q, byte_valid_d;
  logic                    sready;
  logic                    accept;

  assign sready = (state_q == ST_RECEIVE);
  assign accept = i_SVALID & sready;

  // NOTE: every _d gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    data_count_d = data_count_q;
    row_d        = row_q;
    byte_d       = byte_q;
    bit_cnt_d    = bit_cnt_q;
    gap_d        = gap_q;
    byte_valid_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (i_START) begin
          cmd_d        = i_CMD;
          row_d        = '0;
          data_count_d = '0;
          byte_d       = '0;
          bit_cnt_d    = '0;
          state_d      = ST_RECEIVE;
        end
      end
      ST_RECEIVE: begin
        if (accept) begin
          byte_d = {byte_q[6:0], i_SDATA};
          // A full counter means the previous byte is done: this bit opens a new row.
          if (bit_cnt_q == BITS_FULL) begin
            row_d        = row_q + 1'b1;
            data_count_d = '0;
            bit_cnt_d    = BIT_CNT_W'(1);
          end else begin
            data_count_d = DATA_COUNT_W'(bit_cnt_q);
            bit_cnt_d    = bit_cnt_q + 1'b1;
            if (bit_cnt_q == BITS_LAST) begin
              byte_valid_d = 1'b1;
              gap_d        = GAP_LOAD;
              state_d      = ST_GAP;
            end
          end
        end
      end
      ST_GAP: begin
        if (gap_q == '0) begin
          state_d = (row_q == LAST_ROW) ? ST_DONE : ST_RECEIVE;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge i_CLOCK) begin
    if (i_RESET) begin
      state_q      <= ST_IDLE;
      cmd_q        <= '0;
      data_count_q <= '0;
      row_q        <= '0;
      byte_q       <= '0;
      bit_cnt_q    <= '0;
      gap_q        <= '0;
      byte_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      data_count_q <= data_count_d;
      row_q        <= row_d;
      byte_q       <= byte_d;
      bit_cnt_q    <= bit_cnt_d;
      gap_q        <= gap_d;
      byte_valid_q <= byte_valid_d;
    end
  end

  always_comb begin
    o_SREADY     = sready;
    o_CMD        = cmd_q;
    o_DATA_COUNT = data_count_q;
    o_ROW        = row_q;
    o_BYTE       = byte_q;
    o_BYTE_VALID = byte_valid_q;
    o_FRAME_DONE = (state_q == ST_DONE);
    o_BUSY       = (state_q != ST_IDLE);
  end

endmodule

// File: tb/tb_sc_image_serial_receiver.sv
// Directed bench for sc_image_serial_receiver with a small loader-strobe
// monitor; expected values are hand-derived from the frame sequence.
module tb_sc_image_serial_receiver;
  import sc_image_serial_receiver_pkg::*;

  logic       i_CLOCK;
  logic       i_RESET;
  logic       i_START;
  logic [1:0] i_CMD;
  logic       i_SDATA;
  logic       i_SVALID;
  logic       o_SREADY;
  logic [1:0] o_CMD;
  logic [6:0] o_DATA_COUNT;
  logic [3:0] o_ROW;
  logic [7:0] o_BYTE;
  logic       o_BYTE_VALID;
  logic       o_FRAME_DONE;
  logic       o_BUSY;

  int checks   = 0;
  int failures = 0;
  int strobes  = 0;
  int row_sum  = 0;

  sc_image_serial_receiver #(
    .ROWS(8), .BITS_PER_ROW(8), .GAP_CYCLES(2)
  ) dut (
    .i_CLOCK     (i_CLOCK),
    .i_RESET     (i_RESET),
    .i_START     (i_START),
    .i_CMD       (i_CMD),
    .i_SDATA     (i_SDATA),
    .i_SVALID    (i_SVALID),
    .o_SREADY    (o_SREADY),
    .o_CMD       (o_CMD),
    .o_DATA_COUNT(o_DATA_COUNT),
    .o_ROW       (o_ROW),
    .o_BYTE      (o_BYTE),
    .o_BYTE_VALID(o_BYTE_VALID),
    .o_FRAME_DONE(o_FRAME_DONE),
    .o_BUSY      (o_BUSY)
  );

  initial i_CLOCK = 1'b0;
  always #5 i_CLOCK = ~i_CLOCK;

  // Loader model: one active-low row strobe when a byte completes under the load command.
  always @(negedge i_CLOCK) begin
    if (!i_RESET && o_BYTE_VALID && o_CMD == CMD_LOAD_IMAGE) begin
      strobes++;
      row_sum += int'(o_ROW);
    end
  end

  task automatic tick();
    @(posedge i_CLOCK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_sready"}, 32'(o_SREADY), 32'd0);
    check({tag, "_cmd"}, 32'(o_CMD), 32'd0);
    check({tag, "_dcount"}, 32'(o_DATA_COUNT), 32'd0);
    check({tag, "_row"}, 32'(o_ROW), 32'd0);
    check({tag, "_byte"}, 32'(o_BYTE), 32'd0);
    check({tag, "_bvalid"}, 32'(o_BYTE_VALID), 32'd0);
    check({tag, "_fdone"}, 32'(o_FRAME_DONE), 32'd0);
    check({tag, "_busy"}, 32'(o_BUSY), 32'd0);
  endtask

  // Sends one byte MSB first, optionally with random idle cycles, then checks the hold-off.
  task automatic send_byte(input logic [7:0] b, input logic [3:0] row, input bit last,
                           input bit gaps);
    int n;
    for (int i = 7; i >= 0; i--) begin
      if (gaps) begin
        n = $urandom_range(0, 3);
        repeat (n) begin
          i_SVALID = 1'b0;
          i_SDATA  = 1'($urandom_range(0, 1));
          tick();
        end
      end
      i_SVALID = 1'b1;
      i_SDATA  = b[i];
      tick();
      check("bit_dcount", 32'(o_DATA_COUNT), 32'(7 - i));
      check("bit_row", 32'(o_ROW), 32'(row));
    end
    check("byte_value", 32'(o_BYTE), 32'(b));
    check("byte_valid_pulse", 32'(o_BYTE_VALID), 32'd1);
    check("gap1_sready", 32'(o_SREADY), 32'd0);
    i_SDATA = ~b[0];
    tick();
    check("gap2_sready", 32'(o_SREADY), 32'd0);
    check("gap2_bvalid", 32'(o_BYTE_VALID), 32'd0);
    check("gap2_byte", 32'(o_BYTE), 32'(b));
    check("gap2_row", 32'(o_ROW), 32'(row));
    tick();
    check("post_gap_sready", 32'(o_SREADY), 32'(!last));
    check("post_gap_fdone", 32'(o_FRAME_DONE), 32'(last));
    check("post_gap_dcount", 32'(o_DATA_COUNT), 32'd7);
    check("post_gap_byte", 32'(o_BYTE), 32'(b));
    i_SVALID = 1'b0;
  endtask

  initial begin
    logic [7:0] frame1 [8];
    logic [2:0] partial;
    frame1 = '{8'hB2, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    partial = 3'b101;

    i_RESET = 1'b1; i_START = 1'b0; i_CMD = 2'b00; i_SDATA = 1'b0; i_SVALID = 1'b0;
    tick();
    tick();
    check_all_zero("reset");
    i_RESET = 1'b0;

    // Start with a simultaneous valid bit: the bit must not be captured.
    i_START = 1'b1; i_CMD = 2'b00; i_SVALID = 1'b1; i_SDATA = 1'b1;
    tick();
    i_START = 1'b0; i_SVALID = 1'b0;
    check("start_sready", 32'(o_SREADY), 32'd1);
    check("start_busy", 32'(o_BUSY), 32'd1);
    check("start_byte", 32'(o_BYTE), 32'd0);
    check("start_cmd", 32'(o_CMD), 32'd0);

    // Full frame at full rate; a stray start with cmd 01 rides along row 3.
    for (int r = 0; r < 8; r++) begin
      if (r == 3) begin
        i_START = 1'b1;
        i_CMD   = 2'b01;
      end
      send_byte(frame1[r], 4'(r), r == 7, 1'b0);
      if (r == 3) begin
        i_START = 1'b0;
        i_CMD   = 2'b00;
        check("stray_start_cmd", 32'(o_CMD), 32'd0);
      end
    end
    check("done_busy", 32'(o_BUSY), 32'd1);
    tick();
    check("idle_fdone", 32'(o_FRAME_DONE), 32'd0);
    check("idle_busy", 32'(o_BUSY), 32'd0);
    check("idle_sready", 32'(o_SREADY), 32'd0);
    check("idle_row_hold", 32'(o_ROW), 32'd7);
    check("idle_byte_hold", 32'(o_BYTE), 32'h08);
    check("idle_dcount_hold", 32'(o_DATA_COUNT), 32'd7);
    check("frame1_strobes", 32'(strobes), 32'd8);
    check("frame1_row_sum", 32'(row_sum), 32'd28);

    // Non-load command frame with random valid gaps, then reset mid row 2.
    i_START = 1'b1; i_CMD = 2'b01;
    tick();
    i_START = 1'b0;
    check("frame2_cmd", 32'(o_CMD), 32'd1);
    check("frame2_row_clear", 32'(o_ROW), 32'd0);
    send_byte(8'h5A, 4'd0, 1'b0, 1'b1);
    send_byte(8'hC3, 4'd1, 1'b0, 1'b1);
    for (int i = 2; i >= 0; i--) begin
      i_SVALID = 1'b1;
      i_SDATA  = partial[i];
      tick();
    end
    check("partial_row", 32'(o_ROW), 32'd2);
    check("partial_dcount", 32'(o_DATA_COUNT), 32'd2);
    check("partial_byte", 32'(o_BYTE), 32'h1D);
    i_RESET = 1'b1;
    tick();
    check_all_zero("midreset");
    i_RESET = 1'b0; i_SVALID = 1'b0;
    check("frame2_strobes", 32'(strobes), 32'd8);

    i_START = 1'b1; i_CMD = 2'b00;
    tick();
    i_START = 1'b0;
    check("restart_row", 32'(o_ROW), 32'd0);
    send_byte(8'h3C, 4'd0, 1'b0, 1'b0);
    tick();
    check("restart_strobes", 32'(strobes), 32'd9);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
